// File: rtl/spi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_responder_pkg
// Description : Shared opcode constants and FSM state encoding for the
//               25xx-style SPI memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_mem_responder_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRDI  = 8'h04;
    localparam logic [7:0] CMD_RDSR  = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_DATA    = 3'd4,
        ST_IGNORE  = 3'd5,
        ST_STATUS  = 3'd6
    } state_t;

endpackage : spi_mem_responder_pkg
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_pin_sync
// Description : Multi-stage synchroniser for SCK, CE and MOSI into the clk
//               domain, plus edge detection on the polarity-normalised SCK
//               and on CE.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n        system clock, async active-low reset
//               sck_i/ce_i/mosi_i raw SPI pins
//               cpol_i            SCK idle level (normalises edge sense)
//               sck_lead_o        normalised SCK 0->1 (one clk pulse)
//               sck_trail_o       normalised SCK 1->0 (one clk pulse)
//               ce_sync_o         synchronised CE (active low)
//               ce_fall_o         synchronised CE 1->0 (one clk pulse)
//               mosi_sync_o       synchronised MOSI, aligned with SCK edges
// ============================================================================
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_i,
    input  logic ce_i,
    input  logic mosi_i,
    input  logic cpol_i,
    output logic sck_lead_o,
    output logic sck_trail_o,
    output logic ce_sync_o,
    output logic ce_fall_o,
    output logic mosi_sync_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] ce_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   ce_prev_q;
    logic                   sck_norm;

    // After normalisation a leading edge is always 0->1 regardless of CPOL.
    assign sck_norm = sck_sync_q[SYNC_STAGES-1] ^ cpol_i;

    // CE and MOSI reset to their idle-high levels so no false CE fall is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q  <= '0;
            ce_sync_q   <= '1;
            mosi_sync_q <= '1;
            sck_prev_q  <= 1'b0;
            ce_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], ce_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q  <= sck_norm;
            ce_prev_q   <= ce_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_lead_o  = sck_norm & ~sck_prev_q;
    assign sck_trail_o = ~sck_norm & sck_prev_q;
    assign ce_sync_o   = ce_sync_q[SYNC_STAGES-1];
    assign ce_fall_o   = ce_prev_q & ~ce_sync_q[SYNC_STAGES-1];
    assign mosi_sync_o = mosi_sync_q[SYNC_STAGES-1];

endmodule : spi_pin_sync
`default_nettype wire

// File: rtl/spi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_responder
// Description : SPI responder emulating a 25xx-style byte memory
//               (READ 0x03 / WRITE 0x02, 16-bit address). All SPI pins are
//               oversampled in the clk domain; nothing is clocked by SCK.
//               Optional macro SPI_RESP_STATUS_EN adds RDSR (0x05) returning
//               {7'b0, wr_seen} and WRDI (0x04) clearing wr_seen.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n            system clock, async active-low reset
//               sck_i, ce_i, mosi_i   SPI inputs (CE active low)
//               miso_o                SPI output, MSB first
//               cpol_i, cpha_i        SPI mode select
//               rx_byte_o, rx_valid_o last received byte and its pulse
//               wr_strobe_o, wr_addr_o memory commit pulse and address
//               busy_o                synchronised ~CE
// ============================================================================
module spi_mem_responder
    import spi_mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sck_i,
    input  logic        ce_i,
    input  logic        mosi_i,
    output logic        miso_o,
    input  logic        cpol_i,
    input  logic        cpha_i,
    output logic [7:0]  rx_byte_o,
    output logic        rx_valid_o,
    output logic        wr_strobe_o,
    output logic [15:0] wr_addr_o,
    output logic        busy_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic sck_lead, sck_trail, ce_s, ce_fall, mosi_s;
    logic sample_edge, shift_edge;

    spi_pin_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_pin_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck_i       (sck_i),
        .ce_i        (ce_i),
        .mosi_i      (mosi_i),
        .cpol_i      (cpol_i),
        .sck_lead_o  (sck_lead),
        .sck_trail_o (sck_trail),
        .ce_sync_o   (ce_s),
        .ce_fall_o   (ce_fall),
        .mosi_sync_o (mosi_s)
    );

    assign sample_edge = cpha_i ? sck_trail : sck_lead;
    assign shift_edge  = cpha_i ? sck_lead  : sck_trail;

    state_t      state_q;
    logic        op_write_q;
    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_sr_q;
    logic [7:0]  tx_sr_q;
    logic [7:0]  addr_hi_q;
    logic [15:0] addr_q;
    logic [7:0]  mem_q [MEM_DEPTH];
    logic        miso_q;
    logic [7:0]  rx_byte_q;
    logic        rx_valid_q;
    logic        wr_strobe_q;
    logic [15:0] wr_addr_q;
`ifdef SPI_RESP_STATUS_EN
    logic        wr_seen_q;
`endif

    logic [7:0]  rx_byte_d;
    logic [15:0] addr_lo_d;
    logic [15:0] addr_inc_d;

    assign rx_byte_d  = {rx_sr_q, mosi_s};
    assign addr_lo_d  = {addr_hi_q, rx_byte_d};
    assign addr_inc_d = addr_q + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_write_q  <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 7'h7F;
            tx_sr_q     <= 8'hFF;
            addr_hi_q   <= 8'h00;
            addr_q      <= 16'h0000;
            miso_q      <= 1'b1;
            rx_byte_q   <= 8'hFF;
            rx_valid_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 16'h0000;
`ifdef SPI_RESP_STATUS_EN
            wr_seen_q   <= 1'b0;
`endif
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= 8'hFF;
            end
        end else begin
            rx_valid_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            if (ce_s) begin
                // CE high has priority over any edge in the same clk, so a
                // partial (or just-completed) byte is dropped here.
                state_q   <= ST_IDLE;
                bit_cnt_q <= 3'd0;
                tx_sr_q   <= 8'hFF;
                miso_q    <= 1'b1;
            end else if (ce_fall) begin
                // The first byte out is always the 0xFF filler, so driving
                // its MSB now is simply MISO=1 with the shifter left full.
                state_q   <= ST_CMD;
                bit_cnt_q <= 3'd0;
                tx_sr_q   <= 8'hFF;
                miso_q    <= 1'b1;
            end else begin
                if (shift_edge) begin
                    miso_q  <= tx_sr_q[7];
                    tx_sr_q <= {tx_sr_q[6:0], 1'b1};
                end
                if (sample_edge) begin
                    rx_sr_q   <= rx_byte_d[6:0];
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_q  <= rx_byte_d;
                        rx_valid_q <= 1'b1;
                        // Next byte is loaded on the sample edge so its MSB
                        // goes out on the following shift edge, ahead of the
                        // next byte's first sample.
                        tx_sr_q    <= 8'hFF;
                        case (state_q)
                            ST_CMD: begin
                                if (rx_byte_d == CMD_READ || rx_byte_d == CMD_WRITE) begin
                                    op_write_q <= (rx_byte_d == CMD_WRITE);
                                    state_q    <= ST_ADDR_HI;
                                end
`ifdef SPI_RESP_STATUS_EN
                                else if (rx_byte_d == CMD_RDSR) begin
                                    state_q <= ST_STATUS;
                                    tx_sr_q <= {7'b0, wr_seen_q};
                                end else if (rx_byte_d == CMD_WRDI) begin
                                    wr_seen_q <= 1'b0;
                                    state_q   <= ST_IGNORE;
                                end
`endif
                                else begin
                                    state_q <= ST_IGNORE;
                                end
                            end
                            ST_ADDR_HI: begin
                                addr_hi_q <= rx_byte_d;
                                state_q   <= ST_ADDR_LO;
                            end
                            ST_ADDR_LO: begin
                                addr_q  <= addr_lo_d;
                                state_q <= ST_DATA;
                                if (!op_write_q) begin
                                    tx_sr_q <= mem_q[addr_lo_d[IDX_W-1:0]];
                                end
                            end
                            ST_DATA: begin
                                // addr_q is the address of the byte that just
                                // completed; the 16-bit increment wraps freely.
                                addr_q <= addr_inc_d;
                                if (op_write_q) begin
                                    mem_q[addr_q[IDX_W-1:0]] <= rx_byte_d;
                                    wr_strobe_q <= 1'b1;
                                    wr_addr_q   <= addr_q;
`ifdef SPI_RESP_STATUS_EN
                                    wr_seen_q   <= 1'b1;
`endif
                                end else begin
                                    tx_sr_q <= mem_q[addr_inc_d[IDX_W-1:0]];
                                end
                            end
`ifdef SPI_RESP_STATUS_EN
                            ST_STATUS: begin
                                tx_sr_q <= {7'b0, wr_seen_q};
                            end
`endif
                            default: begin
                            end
                        endcase
                    end
                end
            end
        end
    end

    assign miso_o      = miso_q;
    assign rx_byte_o   = rx_byte_q;
    assign rx_valid_o  = rx_valid_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign busy_o      = ~ce_s;

endmodule : spi_mem_responder
`default_nettype wire

// File: tb/tb_spi_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_mem_responder
// Description : Self-checking bench for spi_mem_responder. Drives SPI
//               transactions as a master in all four modes and compares the
//               DUT against a transaction-level memory model. Honors
//               SPI_RESP_STATUS_EN for the RDSR/WRDI cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_responder;

    localparam int MEM_DEPTH = 64;
    localparam int HALF      = 50;

    logic        clk, rst_n, sck, ce, mosi, cpol, cpha;
    logic        miso_o, rx_valid_o, wr_strobe_o, busy_o;
    logic [7:0]  rx_byte_o;
    logic [15:0] wr_addr_o;

    spi_mem_responder #(.MEM_DEPTH(MEM_DEPTH), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sck_i       (sck),
        .ce_i        (ce),
        .mosi_i      (mosi),
        .miso_o      (miso_o),
        .cpol_i      (cpol),
        .cpha_i      (cpha),
        .rx_byte_o   (rx_byte_o),
        .rx_valid_o  (rx_valid_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_addr_o   (wr_addr_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    logic [7:0]  model_mem [MEM_DEPTH];
    logic        model_wr_seen;
    logic [7:0]  tx_buf[$];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_miso[$];
    logic [7:0]  exp_rx_q[$];
    logic [23:0] exp_wr_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < MEM_DEPTH; i++) model_mem[i] = 8'hFF;
        model_wr_seen = 1'b0;
    endtask

    // Transaction-level expectations: byte 0 opcode, bytes 1-2 address,
    // data from byte 3 on; everything not carrying read data is 0xFF.
    task automatic model_txn(input int nfull);
        logic [7:0]  op;
        logic [7:0]  m;
        logic [15:0] a;
        exp_miso.delete();
        op = tx_buf[0];
        for (int k = 0; k < nfull; k++) begin
            m = 8'hFF;
            exp_rx_q.push_back(tx_buf[k]);
            if ((op == 8'h03 || op == 8'h02) && k >= 3) begin
                a = {tx_buf[1], tx_buf[2]} + 16'(k - 3);
                if (op == 8'h03) begin
                    m = model_mem[int'(a) % MEM_DEPTH];
                end else begin
                    model_mem[int'(a) % MEM_DEPTH] = tx_buf[k];
                    exp_wr_q.push_back({a, tx_buf[k]});
                    model_wr_seen = 1'b1;
                end
            end
`ifdef SPI_RESP_STATUS_EN
            else if (op == 8'h05 && k >= 1) begin
                m = {7'b0, model_wr_seen};
            end
            if (op == 8'h04 && k == 0) model_wr_seen = 1'b0;
`endif
            exp_miso.push_back(m);
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!cpha) begin
                mosi = tx[i];
                #HALF;
                rx[i] = miso_o;
                sck = ~cpol;
                #HALF;
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = tx[i];
                #HALF;
                rx[i] = miso_o;
                sck = cpol;
                #HALF;
            end
        end
    endtask

    task automatic spi_txn(input int nfull, input int part_bits, input bit rst_mid);
        logic [7:0] r;
        model_txn(nfull);
        got_q.delete();
        ce = 1'b0;
        #100;
        check("busy_in_txn", {31'b0, busy_o}, 32'd1);
        for (int k = 0; k < nfull; k++) begin
            spi_byte(tx_buf[k], 8, r);
            got_q.push_back(r);
        end
        if (part_bits > 0) spi_byte(tx_buf[nfull], part_bits, r);
        if (rst_mid) begin
            rst_n = 1'b0;
            #40;
            model_reset();
            rst_n = 1'b1;
        end
        #HALF;
        ce = 1'b1;
        #200;
        check("busy_after_txn", {31'b0, busy_o}, 32'd0);
        for (int k = 0; k < nfull; k++) check("miso_byte", {24'b0, got_q[k]}, {24'b0, exp_miso[k]});
    endtask

    task automatic set_mode(input logic p, input logic h);
        cpol = p;
        cpha = h;
        sck  = p;
        #200;
    endtask

    // Every received byte and every commit is checked against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid_o) begin
                if (exp_rx_q.size() == 0) check("rx_valid_unexpected", {24'b0, rx_byte_o}, 32'hFFFF_FFFF);
                else check("rx_byte", {24'b0, rx_byte_o}, {24'b0, exp_rx_q.pop_front()});
            end
            if (wr_strobe_o) begin
                if (exp_wr_q.size() == 0) begin
                    check("wr_strobe_unexpected", {16'b0, wr_addr_o}, 32'hFFFF_FFFF);
                end else begin
                    logic [23:0] e;
                    e = exp_wr_q.pop_front();
                    check("wr_addr", {16'b0, wr_addr_o}, {16'b0, e[23:8]});
                    check("wr_data", {24'b0, rx_byte_o}, {24'b0, e[7:0]});
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b1; mosi = 1'b1; cpol = 1'b0; cpha = 1'b0; sck = 1'b0;
        model_reset();
        #50;
        check("rst_miso",      {31'b0, miso_o},      32'd1);
        check("rst_busy",      {31'b0, busy_o},      32'd0);
        check("rst_rx_valid",  {31'b0, rx_valid_o},  32'd0);
        check("rst_wr_strobe", {31'b0, wr_strobe_o}, 32'd0);
        check("rst_wr_addr",   {16'b0, wr_addr_o},   32'd0);
        check("rst_rx_byte",   {24'b0, rx_byte_o},   32'hFF);
        #50;
        rst_n = 1'b1;
        #100;

        // Memory after reset reads back erased.
        set_mode(1'b0, 1'b0);
        tx_buf = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00};
        spi_txn(5, 0, 1'b0);
        check("lit_reset_mem", {24'b0, got_q[3]}, 32'hFF);

        // Mode 0 write of two bytes at 0x0005.
        tx_buf = '{8'h02, 8'h00, 8'h05, 8'hA5, 8'h3C};
        spi_txn(5, 0, 1'b0);

        // Read back in every mode.
        for (int md = 0; md < 4; md++) begin
            set_mode(md[1], md[0]);
            tx_buf = '{8'h03, 8'h00, 8'h05, 8'h00, 8'h00};
            spi_txn(5, 0, 1'b0);
            check("lit_read_a5", {24'b0, got_q[3]}, 32'hA5);
            check("lit_read_3c", {24'b0, got_q[4]}, 32'h3C);
        end

        // Index wrap at MEM_DEPTH and 16-bit address wrap.
        set_mode(1'b0, 1'b0);
        tx_buf = '{8'h02, 8'h00, 8'h3F, 8'h11, 8'h22};
        spi_txn(5, 0, 1'b0);
        tx_buf = '{8'h03, 8'h00, 8'h00, 8'h00};
        spi_txn(4, 0, 1'b0);
        check("lit_wrap_idx0", {24'b0, got_q[3]}, 32'h22);
        tx_buf = '{8'h02, 8'hFF, 8'hFF, 8'h33, 8'h44};
        spi_txn(5, 0, 1'b0);
        tx_buf = '{8'h03, 8'h00, 8'h3F, 8'h00, 8'h00};
        spi_txn(5, 0, 1'b0);
        check("lit_wrap16_hi", {24'b0, got_q[3]}, 32'h33);
        check("lit_wrap16_lo", {24'b0, got_q[4]}, 32'h44);

        // Unknown opcode: MISO stays high, nothing committed.
        tx_buf = '{8'h9F, 8'h12, 8'h34, 8'h56};
        spi_txn(4, 0, 1'b0);
        check("lit_unknown_op", {24'b0, got_q[3]}, 32'hFF);

        // Abort after 4 data bits: no commit, next transaction decodes.
        set_mode(1'b1, 1'b1);
        tx_buf = '{8'h02, 8'h00, 8'h07, 8'h5A};
        spi_txn(3, 4, 1'b0);
        tx_buf = '{8'h03, 8'h00, 8'h07, 8'h00};
        spi_txn(4, 0, 1'b0);
        check("lit_abort_mem", {24'b0, got_q[3]}, 32'hFF);

        // Reset mid-transfer erases memory.
        set_mode(1'b0, 1'b0);
        tx_buf = '{8'h02, 8'h00, 8'h06, 8'h99};
        spi_txn(3, 5, 1'b1);
        tx_buf = '{8'h03, 8'h00, 8'h05, 8'h00};
        spi_txn(4, 0, 1'b0);
        check("lit_rst_mem", {24'b0, got_q[3]}, 32'hFF);

        // Status register commands.
        tx_buf = '{8'h05, 8'h00, 8'h00};
        spi_txn(3, 0, 1'b0);
`ifdef SPI_RESP_STATUS_EN
        check("lit_rdsr_reset", {24'b0, got_q[1]}, 32'h00);
`else
        check("lit_rdsr_ignored", {24'b0, got_q[1]}, 32'hFF);
`endif
        tx_buf = '{8'h02, 8'h00, 8'h02, 8'h12};
        spi_txn(4, 0, 1'b0);
        tx_buf = '{8'h05, 8'h00, 8'h00};
        spi_txn(3, 0, 1'b0);
`ifdef SPI_RESP_STATUS_EN
        check("lit_rdsr_written", {24'b0, got_q[2]}, 32'h01);
`else
        check("lit_rdsr_ignored2", {24'b0, got_q[2]}, 32'hFF);
`endif
        tx_buf = '{8'h04};
        spi_txn(1, 0, 1'b0);
        tx_buf = '{8'h05, 8'h00};
        spi_txn(2, 0, 1'b0);
`ifdef SPI_RESP_STATUS_EN
        check("lit_rdsr_wrdi", {24'b0, got_q[1]}, 32'h00);
`else
        check("lit_rdsr_ignored3", {24'b0, got_q[1]}, 32'hFF);
`endif

        #200;
        check("rx_queue_drained", exp_rx_q.size(), 32'd0);
        check("wr_queue_drained", exp_wr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_spi_mem_responder
`default_nettype wire
